reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Arithmetic/branch reservation station that sits directly upstream of the ALU in the Tomasulo core.
- Buffers dispatched instructions and snoops the two result buses (ALU and LSB) to resolve pending operands.
- Each cycle, issues at most one fully-ready entry to the ALU through a registered output stage.
- Drains completely on a ROB flush (branch mispredict).

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- IDX_W, 4, log2(RS_SIZE).
- TAG_W, 4, ROB tag width.
- OP_W, 6, internal opcode width (shared opcode encoding).
- XLEN, 32, data/pc/imm width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  ROB mispredict clear
- disp_valid  in  1  dispatch an instruction this cycle
- disp_op  in  OP_W  opcode
- disp_v1 / disp_v2  in  XLEN  operand values (meaningful when ready)
- disp_q1 / disp_q2  in  TAG_W  producing ROB tag when not ready
- disp_r1 / disp_r2  in  1  operand already ready
- disp_imm  in  XLEN  immediate
- disp_pc  in  XLEN  instruction pc
- disp_tag  in  TAG_W  destination ROB tag
- full  out  1  no free entry
- alu_cdb_valid, alu_cdb_tag, alu_cdb_data  in  1/TAG_W/XLEN  ALU broadcast
- lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data  in  1/TAG_W/XLEN  LSB broadcast
- op_to_alu  out  OP_W
- v1_to_alu / v2_to_alu / imm_to_alu / pc_to_alu  out  XLEN
- tag_to_alu  out  TAG_W  ROB tag that travels with the result
- is_empty_to_alu  out  1  high = no valid instruction on the issue outputs

Behaviour:
- Reset (asynchronous):
  - All entry busy bits cleared.
  - is_empty_to_alu=1; all other issue outputs 0.
  - full=0; count=0.
- Entry fields: busy, op, v1, v2, r1, r2, q1, q2, imm, pc, tag.
- full = (count == RS_SIZE), derived from the registered count. The dispatcher must not assert disp_valid while full; a dispatch while full is dropped and raises an assertion in simulation.
- Dispatch:
  - Writes the lowest-index free entry at the posedge.
  - Same-cycle forwarding: if disp_rX=0 and either CDB is valid with a tag equal to disp_qX in that cycle, the entry is stored with rX=1 and vX=the CDB data.
- Wakeup:
  - Each cycle, every busy entry with rX=0 compares qX against both CDBs.
  - On a match it captures the data and sets rX=1 at the posedge.
  - If both CDBs match (illegal, since ROB tags are unique), the ALU bus wins.
- Select:
  - Combinational over registered state: the lowest-index entry with busy & r1 & r2.
  - The sub-module produces a found flag and the index.
- Issue:
  - If found, the selected entry's fields are registered onto the *_to_alu outputs, is_empty_to_alu is set to 0, and the entry is freed, all at the same posedge.
  - If none is found, is_empty_to_alu=1 and the other outputs hold their last values.
  - One instruction is issued per cycle at most.
- Latency:
  - An instruction dispatched with both operands ready appears on the ALU outputs 2 edges after disp_valid (write edge, then issue edge).
  - An operand woken by the CDB in cycle N makes its entry eligible in cycle N+1 and places it on the outputs at the end of N+1.
- Count:
  - count' = count + dispatch − issue.
  - Simultaneous dispatch and issue leaves count unchanged.
  - A dispatch may land in the slot freed by the same-cycle issue only from the next cycle onward; the free search uses registered busy bits.
- Flush:
  - Synchronous and highest priority.
  - At the posedge, all busy bits are cleared, count=0, and is_empty_to_alu=1.
  - A dispatch or CDB event in the flush cycle is ignored.
  - Operation resumes normally in the following cycle.
- Reset mid-operation: immediate return to the reset state regardless of pending entries.
- Immediates are passed unmodified; sign extension is the ALU's job.

Decomposition:
- Shared package: OP_W, XLEN, TAG_W, opcode constants (LUI…AND), and the RS entry struct typedef.
- One sub-module, rs_select: a parameterized lowest-index priority encoder (request vector → found, index). It is instantiated twice: once for the free-slot search and once for the ready-slot search.

Test Plan:
- Reset then dispatch ADD with tag=3, v1=5, v2=7, r1=r2=1 → two edges later: op_to_alu=ADD, v1=5, v2=7, tag_to_alu=3, is_empty_to_alu=0; next cycle is_empty_to_alu=1.
- Dispatch SUB with r1=0, q1=6, v2=2, then alu_cdb_valid tag=6 data=10 two cycles later → v1_to_alu=10 one cycle after the broadcast edge; nothing is issued before that.
- Dispatch with r2=0, q2=9 in the same cycle as lsb_cdb_valid tag=9 data=0xFFFF_FFFF → entry stored ready; issued next edge with v2=0xFFFF_FFFF.
- Dispatch 16 entries all waiting on tag 1 → full=1 after the 16th edge; broadcast tag 1 → entries issue in index order 0..15 over 16 cycles; full drops after the first issue.
- Fill 5 waiting entries, assert flush together with a dispatch and a matching CDB → count=0, full=0, is_empty_to_alu=1; no issue occurs afterwards.
- Assert rst asynchronously mid-issue (between edges) → is_empty_to_alu=1 immediately; all entries gone after release.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// -----------------------------------------------------------------------------
// reservation_station_pkg: shared widths, opcodes, RS entry type, CDB snoop.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package reservation_station_pkg;

  localparam int OP_W        = 6;
  localparam int XLEN        = 32;
  localparam int TAG_W       = 4;
  localparam int RS_SIZE_DEF = 16;
  localparam int IDX_W_DEF   = 4;

  localparam logic [OP_W-1:0] OP_LUI   = 6'd0;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd1;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd2;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd3;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd6;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd7;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd8;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd9;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd10;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd11;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd12;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd13;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd14;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd15;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd16;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd17;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd18;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd19;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd20;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd21;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd22;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd23;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd24;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd25;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd26;
  localparam logic [OP_W-1:0] OP_OR    = 6'd27;
  localparam logic [OP_W-1:0] OP_AND   = 6'd28;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
    logic             r1;
    logic             r2;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] tag;
  } rs_entry_t;

  typedef struct packed {
    logic            rdy;
    logic [XLEN-1:0] val;
  } operand_t;

  // Resolve one operand against both result buses; the ALU bus wins a double hit.
  function automatic operand_t snoop(
    input logic             rdy,
    input logic [TAG_W-1:0] q,
    input logic [XLEN-1:0]  v,
    input logic             alu_v,
    input logic [TAG_W-1:0] alu_t,
    input logic [XLEN-1:0]  alu_d,
    input logic             lsb_v,
    input logic [TAG_W-1:0] lsb_t,
    input logic [XLEN-1:0]  lsb_d
  );
    operand_t res;
    res.rdy = rdy;
    res.val = v;
    if (!rdy) begin
      if (alu_v && (alu_t == q)) begin
        res.rdy = 1'b1;
        res.val = alu_d;
      end else if (lsb_v && (lsb_t == q)) begin
        res.rdy = 1'b1;
        res.val = lsb_d;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reservation_station_rs_select.sv
// -----------------------------------------------------------------------------
// rs_select: lowest-index priority encoder (request vector -> found, index).
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reservation_station.sv
// -----------------------------------------------------------------------------
// reservation_station: ALU/branch RS with CDB snooping and registered issue.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [XLEN-1:0]  disp_v1,
  input  logic [XLEN-1:0]  disp_v2,
  input  logic [TAG_W-1:0] disp_q1,
  input  logic [TAG_W-1:0] disp_q2,
  input  logic             disp_r1,
  input  logic             disp_r2,
  input  logic [XLEN-1:0]  disp_imm,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic [TAG_W-1:0] disp_tag,
  output logic             full,
  input  logic             alu_cdb_valid,
  input  logic [TAG_W-1:0] alu_cdb_tag,
  input  logic [XLEN-1:0]  alu_cdb_data,
  input  logic             lsb_cdb_valid,
  input  logic [TAG_W-1:0] lsb_cdb_tag,
  input  logic [XLEN-1:0]  lsb_cdb_data,
  output logic [OP_W-1:0]  op_to_alu,
  output logic [XLEN-1:0]  v1_to_alu,
  output logic [XLEN-1:0]  v2_to_alu,
  output logic [XLEN-1:0]  imm_to_alu,
  output logic [XLEN-1:0]  pc_to_alu,
  output logic [TAG_W-1:0] tag_to_alu,
  output logic             is_empty_to_alu
);

  rs_entry_t entries_q [RS_SIZE];
  rs_entry_t entries_d [RS_SIZE];

  logic [IDX_W:0]   count_q, count_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [XLEN-1:0]  v1_q, v1_d;
  logic [XLEN-1:0]  v2_q, v2_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             empty_q, empty_d;

  logic [RS_SIZE-1:0] free_req;
  logic [RS_SIZE-1:0] ready_req;
  logic               free_found;
  logic               ready_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   ready_idx;
  logic               disp_fire;
  logic               issue_fire;

  for (genvar i = 0; i < RS_SIZE; i++) begin : g_req
    assign free_req[i]  = !entries_q[i].busy;
    assign ready_req[i] = entries_q[i].busy & entries_q[i].r1 & entries_q[i].r2;
  end

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
    .req   (free_req),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_sel (
    .req   (ready_req),
    .found (ready_found),
    .idx   (ready_idx)
  );

  assign full       = (count_q == (IDX_W + 1)'(RS_SIZE));
  assign disp_fire  = disp_valid && free_found && !flush;
  assign issue_fire = ready_found && !flush;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i] = entries_q[i];
    end
    op_d    = op_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    tag_d   = tag_q;
    empty_d = 1'b1;

    for (int i = 0; i < RS_SIZE; i++) begin
      if (entries_q[i].busy) begin
        {entries_d[i].r1, entries_d[i].v1} = snoop(entries_q[i].r1, entries_q[i].q1,
            entries_q[i].v1, alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
            lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data);
        {entries_d[i].r2, entries_d[i].v2} = snoop(entries_q[i].r2, entries_q[i].q2,
            entries_q[i].v2, alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
            lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data);
      end
    end

    if (issue_fire) begin
      op_d    = entries_q[ready_idx].op;
      v1_d    = entries_q[ready_idx].v1;
      v2_d    = entries_q[ready_idx].v2;
      imm_d   = entries_q[ready_idx].imm;
      pc_d    = entries_q[ready_idx].pc;
      tag_d   = entries_q[ready_idx].tag;
      empty_d = 1'b0;
      entries_d[ready_idx].busy = 1'b0;
    end

    // The free slot comes from registered busy bits, so it never aliases the issue slot.
    if (disp_fire) begin
      entries_d[free_idx].busy = 1'b1;
      entries_d[free_idx].op   = disp_op;
      entries_d[free_idx].q1   = disp_q1;
      entries_d[free_idx].q2   = disp_q2;
      entries_d[free_idx].imm  = disp_imm;
      entries_d[free_idx].pc   = disp_pc;
      entries_d[free_idx].tag  = disp_tag;
      {entries_d[free_idx].r1, entries_d[free_idx].v1} = snoop(disp_r1, disp_q1, disp_v1,
          alu_cdb_valid, alu_cdb_tag, alu_cdb_data, lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data);
      {entries_d[free_idx].r2, entries_d[free_idx].v2} = snoop(disp_r2, disp_q2, disp_v2,
          alu_cdb_valid, alu_cdb_tag, alu_cdb_data, lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data);
    end

    count_d = count_q + (IDX_W + 1)'(disp_fire) - (IDX_W + 1)'(issue_fire);

    if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_d[i].busy = 1'b0;
      end
      count_d = '0;
      empty_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
      op_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      tag_q   <= '0;
      empty_q <= 1'b1;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q <= count_d;
      op_q    <= op_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
      empty_q <= empty_d;
    end
  end

  assign op_to_alu       = op_q;
  assign v1_to_alu       = v1_q;
  assign v2_to_alu       = v2_q;
  assign imm_to_alu      = imm_q;
  assign pc_to_alu       = pc_q;
  assign tag_to_alu      = tag_q;
  assign is_empty_to_alu = empty_q;

  // A dispatch into a full station is silently lost in hardware.
  a_no_disp_when_full: assert property (@(posedge clk) disable iff (rst)
    !(disp_valid && full && !flush));

endmodule

`default_nettype wire

// File: tb/tb_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_reservation_station: random + directed stimulus against a queue scoreboard.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_reservation_station;
  import reservation_station_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             disp_valid;
  logic [OP_W-1:0]  disp_op;
  logic [XLEN-1:0]  disp_v1, disp_v2, disp_imm, disp_pc;
  logic [TAG_W-1:0] disp_q1, disp_q2, disp_tag;
  logic             disp_r1, disp_r2;
  logic             full;
  logic             alu_cdb_valid, lsb_cdb_valid;
  logic [TAG_W-1:0] alu_cdb_tag, lsb_cdb_tag;
  logic [XLEN-1:0]  alu_cdb_data, lsb_cdb_data;
  logic [OP_W-1:0]  op_to_alu;
  logic [XLEN-1:0]  v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;
  logic [TAG_W-1:0] tag_to_alu;
  logic             is_empty_to_alu;

  reservation_station dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_r1(disp_r1), .disp_r2(disp_r2),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_tag(disp_tag), .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_data(lsb_cdb_data),
    .op_to_alu(op_to_alu), .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu),
    .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu), .tag_to_alu(tag_to_alu),
    .is_empty_to_alu(is_empty_to_alu)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               empty;
    bit               full;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  v1, v2, imm, pc;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    bit               busy, r1, r2;
    logic [TAG_W-1:0] q1, q2, tag;
    logic [XLEN-1:0]  v1, v2, imm, pc;
    logic [OP_W-1:0]  op;
  } slot_t;

  exp_t  exp_q[$];
  slot_t m_rs[16];
  exp_t  m_out;
  int    m_count;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // An operand that is waiting picks up whichever bus carries its tag, ALU first.
  function automatic void wake(input bit r, input logic [TAG_W-1:0] q, input logic [XLEN-1:0] v,
                               output bit ro, output logic [XLEN-1:0] vo);
    ro = r;
    vo = v;
    if (!r && alu_cdb_valid && alu_cdb_tag == q) begin
      ro = 1; vo = alu_cdb_data;
    end else if (!r && lsb_cdb_valid && lsb_cdb_tag == q) begin
      ro = 1; vo = lsb_cdb_data;
    end
  endfunction

  // Reference model: one update per clock edge, expectation pushed for the monitor.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_rs[i].busy = 0;
      m_count = 0;
      m_out.empty = 1; m_out.full = 0; m_out.op = '0; m_out.v1 = '0; m_out.v2 = '0;
      m_out.imm = '0; m_out.pc = '0; m_out.tag = '0;
    end else begin
      int iss, fr;
      iss = -1;
      fr  = -1;
      for (int i = 0; i < 16; i++) begin
        if (iss < 0 && m_rs[i].busy && m_rs[i].r1 && m_rs[i].r2) iss = i;
        if (fr < 0 && !m_rs[i].busy) fr = i;
      end
      if (flush) begin
        for (int i = 0; i < 16; i++) m_rs[i].busy = 0;
        m_out.empty = 1;
      end else begin
        for (int i = 0; i < 16; i++) begin
          if (m_rs[i].busy) begin
            wake(m_rs[i].r1, m_rs[i].q1, m_rs[i].v1, m_rs[i].r1, m_rs[i].v1);
            wake(m_rs[i].r2, m_rs[i].q2, m_rs[i].v2, m_rs[i].r2, m_rs[i].v2);
          end
        end
        if (iss >= 0) begin
          m_out.empty = 0;
          m_out.op = m_rs[iss].op; m_out.v1 = m_rs[iss].v1; m_out.v2 = m_rs[iss].v2;
          m_out.imm = m_rs[iss].imm; m_out.pc = m_rs[iss].pc; m_out.tag = m_rs[iss].tag;
          m_rs[iss].busy = 0;
        end else begin
          m_out.empty = 1;
        end
        if (disp_valid && fr >= 0) begin
          m_rs[fr].busy = 1; m_rs[fr].op = disp_op; m_rs[fr].q1 = disp_q1; m_rs[fr].q2 = disp_q2;
          m_rs[fr].imm = disp_imm; m_rs[fr].pc = disp_pc; m_rs[fr].tag = disp_tag;
          wake(disp_r1, disp_q1, disp_v1, m_rs[fr].r1, m_rs[fr].v1);
          wake(disp_r2, disp_q2, disp_v2, m_rs[fr].r2, m_rs[fr].v2);
        end
      end
      m_count = 0;
      for (int i = 0; i < 16; i++) if (m_rs[i].busy) m_count++;
      m_out.full = (m_count == 16);
      exp_q.push_back(m_out);
    end
  end

  // Monitor: one expectation per edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard: got no expectation, wanted one per edge (t=%0t)", $time);
      end else begin
        n_cmp--;
        e = exp_q.pop_front();
        chk("is_empty_to_alu", 32'(is_empty_to_alu), 32'(e.empty));
        chk("full", 32'(full), 32'(e.full));
        chk("op_to_alu", 32'(op_to_alu), 32'(e.op));
        chk("v1_to_alu", v1_to_alu, e.v1);
        chk("v2_to_alu", v2_to_alu, e.v2);
        chk("imm_to_alu", imm_to_alu, e.imm);
        chk("pc_to_alu", pc_to_alu, e.pc);
        chk("tag_to_alu", 32'(tag_to_alu), 32'(e.tag));
      end
    end
  end

  task automatic idle();
    disp_valid = 0; flush = 0; alu_cdb_valid = 0; lsb_cdb_valid = 0;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                      input bit r1, input bit r2, input logic [TAG_W-1:0] q1,
                      input logic [TAG_W-1:0] q2, input logic [TAG_W-1:0] tag);
    disp_valid = 1; disp_op = op; disp_v1 = v1; disp_v2 = v2; disp_r1 = r1; disp_r2 = r2;
    disp_q1 = q1; disp_q2 = q2; disp_tag = tag;
    disp_imm = $urandom; disp_pc = $urandom;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    disp_op = '0; disp_v1 = '0; disp_v2 = '0; disp_q1 = '0; disp_q2 = '0; disp_r1 = 0;
    disp_r2 = 0; disp_imm = '0; disp_pc = '0; disp_tag = '0;
    alu_cdb_tag = '0; alu_cdb_data = '0; lsb_cdb_tag = '0; lsb_cdb_data = '0;
    repeat (2) @(negedge clk);
    chk("reset is_empty_to_alu", 32'(is_empty_to_alu), 32'd1);
    chk("reset full", 32'(full), 32'd0);
    chk("reset v1_to_alu", v1_to_alu, 32'd0);
    rst = 1'b0;

    // Ready ADD: on the outputs two edges later.
    @(negedge clk); disp(OP_ADD, 5, 7, 1, 1, 0, 0, 3);
    cycles(4);

    // SUB waiting on tag 6, woken by ALU bus two cycles later.
    disp(OP_SUB, 0, 2, 0, 1, 6, 0, 4);
    cycles(2);
    alu_cdb_valid = 1; alu_cdb_tag = 6; alu_cdb_data = 10;
    cycles(4);

    // Same-cycle forwarding from the LSB bus.
    disp(OP_AND, 1, 0, 1, 0, 0, 9, 5);
    lsb_cdb_valid = 1; lsb_cdb_tag = 9; lsb_cdb_data = 32'hFFFF_FFFF;
    cycles(4);

    // Sixteen entries all waiting on tag 1, then one broadcast.
    for (int i = 0; i < 16; i++) begin
      disp(OP_OR, 32'(i), 32'(100 + i), 0, 1, 1, 0, 4'(i));
      @(negedge clk); idle();
    end
    cycles(2);
    alu_cdb_valid = 1; alu_cdb_tag = 1; alu_cdb_data = 32'h1234_5678;
    cycles(20);

    // Five waiting entries, then flush alongside a dispatch and a matching CDB.
    for (int i = 0; i < 5; i++) begin
      disp(OP_XOR, 0, 0, 1, 0, 0, 2, 4'(i));
      @(negedge clk); idle();
    end
    flush = 1; disp(OP_ADD, 1, 1, 1, 1, 0, 0, 7);
    alu_cdb_valid = 1; alu_cdb_tag = 2; alu_cdb_data = 32'hAAAA_5555;
    cycles(2);
    alu_cdb_valid = 1; alu_cdb_tag = 2; alu_cdb_data = 32'h5555_AAAA;
    cycles(5);

    // Asynchronous reset in the middle of an issue burst.
    for (int i = 0; i < 4; i++) begin
      disp(OP_SLT, 32'(i + 20), 32'(i + 40), 1, 1, 0, 0, 4'(i + 8));
      if (i < 3) @(negedge clk);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async rst is_empty_to_alu", 32'(is_empty_to_alu), 32'd1);
    chk("async rst full", 32'(full), 32'd0);
    chk("async rst tag_to_alu", 32'(tag_to_alu), 32'd0);
    @(negedge clk); idle(); rst = 1'b0;
    cycles(4);

    // Random traffic on a small tag space so wakeups and double hits happen.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      idle();
      flush = ($urandom_range(0, 49) == 0);
      if (m_count < 16 && $urandom_range(0, 2) != 0)
        disp(6'($urandom_range(0, 28)), $urandom, $urandom, 1'($urandom), 1'($urandom),
             4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom));
      alu_cdb_valid = 1'($urandom); alu_cdb_tag = 4'($urandom_range(0, 7)); alu_cdb_data = $urandom;
      lsb_cdb_valid = 1'($urandom); lsb_cdb_tag = 4'($urandom_range(0, 7)); lsb_cdb_data = $urandom;
    end
    cycles(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
